agusec_bounds_enc: RTL and testbench
====================================

# agusec_bounds_enc

Bounded-pointer encoder for the AGU security path. It takes a source pointer and a length in 16-byte granules, then searches for the smallest exponent whose 7-bit low/high window covers the requested range. It returns a 64-bit pointer whose `ptr_exp`, `ptr_low`, `ptr_hi` and `ptr_on_low` fields are filled in. The bounds-check side decodes exactly these fields, so this block is the producer of what the AGU range check consumes.

## Interface
Parameters:
- none (field positions come from the `ptr_*` macros in struct.sv; the granule address is ptr[43:4], 40 bits)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_vld  in  1  request valid
- in_rdy  out  1  request accepted when in_vld&&in_rdy at a rising edge
- in_ptr  in  64  source pointer; base granule B = in_ptr[43:4]
- in_len  in  41  length in granules; range 1..2^40
- out_vld  out  1  result valid
- out_rdy  in  1  result consumed when out_vld&&out_rdy at a rising edge
- out_ptr  out  64  encoded pointer
- out_exact  out  1  bounds equal the request exactly (no outward rounding)
- out_err  out  1  request is unencodable; out_ptr = in_ptr

## Operation
- States:
  - IDLE → SEARCH on accept, or IDLE → DONE on accept when the request is in error.
  - SEARCH → DONE when the current exponent fits.
  - DONE → IDLE on out_vld&&out_rdy.
- in_rdy = (state==IDLE) && ~rst. No request is accepted while DONE is held.
- On accept, register:
  - B;
  - T = B+in_len-1 (41-bit sum);
  - the untouched in_ptr bits;
  - e = e_start.
- Error at accept: in_len==0, or T>2^40-1. Then out_err=1, out_exact=0, out_ptr=in_ptr, and the block goes directly to DONE.
- Fit test at e<31:
  - Bh=B>>(e+1), Th=T>>(e+1);
  - fit iff Th-Bh<=127 (40-bit unsigned subtraction);
  - result: exp=e, low=Bh[6:0], hi=Th[6:0].
- e==31 always fits (max encoding). In that case low=0 and hi=7'h7f.
- on_low=1 always, because the address equals the base at creation. The wrap case (hi<low) is legal and not an error.
- out_exact=1 iff B[e:0]==0 and T[e:0] is all ones. At e==31, exact iff B==0 and T==2^40-1.
- A fail at e<31 increments e. The exponent never exceeds 31.
- All out_* are registered; each is loaded on the edge that enters DONE.
- Reset values: state IDLE, out_vld 0, out_ptr 0, out_exact 0, out_err 0, e 0.

## Timing
- Each SEARCH cycle tests one exponent.
- If a request is accepted at edge k and fits after n SEARCH cycles, out_vld rises after edge k+n.
  - The minimum is n=1, i.e. out_vld in the second cycle after accept.
- Error path: out_vld is visible the cycle after accept.
- While out_rdy=0, out_vld/out_ptr/out_exact/out_err hold stable.
- Reset in any state abandons the request: the next cycle has out_vld=0, and in_rdy=1 after rst deasserts.
- A request presented during DONE is not accepted until the cycle after the handshake (the block returns to IDLE first).

## Configuration
- AGUSEC_ENC_FASTSTART_EN defined:
  - L = T-B; p = index of L's highest set bit (0 if L==0);
  - e_start = min(31, p>7 ? p-7 : 0);
  - the fit succeeds at e_start or e_start+1, so SEARCH lasts ≤2 cycles.
- Undefined: e_start=0, and SEARCH takes up to 32 cycles. Encoded results are identical either way; only latency differs.

## Structure
- Keep in the shared struct.sv header: the `ptr_exp`/`ptr_low`/`ptr_hi`/`ptr_on_low` field macros, the state encoding, and the max exponent constant 5'h1f.
- One combinational sub-module: agusec_enc_fit. Inputs: B, T, e. Outputs: fit, low, hi, exact. Instantiated once and fed by the exponent register.
- The priority encoder for the fast start lives inside the `ifdef`.

## Test plan
- **Small exact range.** B=0x100, in_len=16 → exp 0, low 0x00, hi 0x07, exact=1, out_err=0. out_vld appears 2 cycles after accept.
- **Round-up case.** B=0x3, in_len=0x100 → exp 0 fails (diff 128), exp 1 fits: low 0x00, hi 0x40, exact=0.
- **Zero length and overflow.** in_len=0 → out_err=1, out_ptr=in_ptr, out_vld the cycle after accept. B=0xFFFFFFFFF0 with in_len=0x20 → out_err=1.
- **Full address space.** B=0, in_len=2^40 → exp 31, low 0, hi 0x7f, exact=1. Without the macro, out_vld appears after 32 SEARCH cycles; with AGUSEC_ENC_FASTSTART_EN, in ≤2.
- **Backpressure.** Hold out_rdy=0 for 5 cycles → outputs stable and in_rdy=0 throughout. The handshake returns the block to IDLE; the next request is then accepted.
- **Mid-search reset.** Assert rst during SEARCH → out_vld=0 next cycle and no result is ever emitted. in_rdy=1 after rst drops.

Source files
------------

// File: rtl/agusec_bounds_enc_pkg.sv
// Shared definitions for the bounded-pointer encoder: pointer field layout,
// FSM state encoding and the maximum exponent.
// Pointer upper 20 bits: exp[63:59] hi[58:52] low[51:45] on_low[44]; address [43:0].
package agusec_bounds_enc_pkg;

  // Largest exponent; a window at this exponent always covers the address space.
  localparam logic [4:0] MAX_EXP = 5'h1f;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Insert the bounds fields above the untouched 44-bit address of base.
  // on_low is always set: the address equals the base when the pointer is made.
  function automatic logic [63:0] pack_ptr(input logic [63:0] base,
                                           input logic [4:0]  exp,
                                           input logic [6:0]  low,
                                           input logic [6:0]  hi);
    return {exp, hi, low, 1'b1, base[43:0]};
  endfunction

endpackage

// File: rtl/agusec_enc_fit.sv
// Window fit test for one exponent: does [B,T] fit a 7-bit low/high window at e?
// Purely combinational, zero latency.
// No flow control; the caller steps e until fit is reported.
module agusec_enc_fit
  import agusec_bounds_enc_pkg::*;
(
  input  logic [39:0] b,
  input  logic [39:0] t,
  input  logic [4:0]  e,
  output logic        fit,
  output logic [6:0]  low,
  output logic [6:0]  hi,
  output logic        exact
);

  logic [5:0]  sh;
  logic [39:0] bh;
  logic [39:0] th;
  logic [39:0] diff;
  logic [39:0] mask;

  // Scale both bounds to window granules and test the span; top exponent is forced.
  always_comb begin
    sh   = {1'b0, e} + 6'd1;
    bh   = b >> sh;
    th   = t >> sh;
    diff = th - bh;
    // Ones in bits [e:0]: the part of the range lost to window rounding.
    mask = ~({40{1'b1}} << sh);
    if (e == MAX_EXP) begin
      fit   = 1'b1;
      low   = 7'h00;
      hi    = 7'h7f;
      exact = (b == 40'd0) && (t == {40{1'b1}});
    end else begin
      fit   = (diff <= 40'd127);
      low   = bh[6:0];
      hi    = th[6:0];
      exact = ((b & mask) == 40'd0) && ((t & mask) == mask);
    end
  end

endmodule

// File: rtl/agusec_bounds_enc.sv
// Bounded-pointer encoder: finds the smallest exponent whose window covers [B, B+len-1].
// Latency: 1 cycle for errors, 1+ search cycles otherwise (<=2 with AGUSEC_ENC_FASTSTART_EN).
// Single request in flight; in_rdy only in IDLE, result held until out_rdy.
module agusec_bounds_enc
  import agusec_bounds_enc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_vld,
  output logic        in_rdy,
  input  logic [63:0] in_ptr,
  input  logic [40:0] in_len,
  output logic        out_vld,
  input  logic        out_rdy,
  output logic [63:0] out_ptr,
  output logic        out_exact,
  output logic        out_err
);

  state_t      state;
  state_t      state_nxt;

  logic [39:0] b_q;
  logic [39:0] t_q;
  logic [63:0] ptr_q;
  logic [4:0]  e_q;

  logic        accept;
  logic [40:0] t_sum;
  logic        acc_err;
  logic [4:0]  e_start;

  logic        fit;
  logic [6:0]  fit_low;
  logic [6:0]  fit_hi;
  logic        fit_exact;

  assign accept = in_vld && in_rdy;

  // Top bound of the request and the unencodable-request check.
  always_comb begin
    t_sum   = {1'b0, in_ptr[43:4]} + in_len - 41'd1;
    acc_err = (in_len == 41'd0) || t_sum[40];
  end

`ifdef AGUSEC_ENC_FASTSTART_EN
  logic [39:0] l_span;
  logic [5:0]  msb;
  logic [5:0]  e_wide;

  // Start the search near the span's magnitude so it ends within two steps.
  always_comb begin
    l_span = t_sum[39:0] - in_ptr[43:4];
    msb    = 6'd0;
    for (int i = 0; i < 40; i++) begin
      if (l_span[i]) msb = i[5:0];
    end
    e_wide  = (msb > 6'd7) ? (msb - 6'd7) : 6'd0;
    e_start = (e_wide > 6'd31) ? MAX_EXP : e_wide[4:0];
  end
`else
  assign e_start = 5'd0;
`endif

  agusec_enc_fit u_fit (
    .b     (b_q),
    .t     (t_q),
    .e     (e_q),
    .fit   (fit),
    .low   (fit_low),
    .hi    (fit_hi),
    .exact (fit_exact)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = acc_err ? ST_DONE : ST_SEARCH;
      ST_SEARCH: if (fit) state_nxt = ST_DONE;
      ST_DONE:   if (out_vld && out_rdy) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: accept only in IDLE and never while reset is asserted.
  always_comb begin
    in_rdy = (state == ST_IDLE) && !rst;
  end

  // Request capture, exponent stepping and registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_q       <= '0;
      t_q       <= '0;
      ptr_q     <= '0;
      e_q       <= '0;
      out_vld   <= 1'b0;
      out_ptr   <= '0;
      out_exact <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            b_q   <= in_ptr[43:4];
            t_q   <= t_sum[39:0];
            ptr_q <= in_ptr;
            e_q   <= e_start;
            if (acc_err) begin
              out_vld   <= 1'b1;
              out_ptr   <= in_ptr;
              out_exact <= 1'b0;
              out_err   <= 1'b1;
            end
          end
        end
        ST_SEARCH: begin
          if (fit) begin
            out_vld   <= 1'b1;
            out_ptr   <= pack_ptr(ptr_q, e_q, fit_low, fit_hi);
            out_exact <= fit_exact;
            out_err   <= 1'b0;
          end else if (e_q != MAX_EXP) begin
            e_q <= e_q + 5'd1;
          end
        end
        ST_DONE: begin
          if (out_rdy) out_vld <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_agusec_bounds_enc.sv
// Directed bench for agusec_bounds_enc with hand-computed expected encodings.
// Inputs driven and outputs sampled on the falling clock edge.
// Result consumption is explicit so holding behaviour can be observed.
module tb_agusec_bounds_enc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_vld;
  logic        in_rdy;
  logic [63:0] in_ptr;
  logic [40:0] in_len;
  logic        out_vld;
  logic        out_rdy;
  logic [63:0] out_ptr;
  logic        out_exact;
  logic        out_err;

  int total = 0;
  int bad   = 0;

  agusec_bounds_enc dut (
    .clk       (clk),
    .rst       (rst),
    .in_vld    (in_vld),
    .in_rdy    (in_rdy),
    .in_ptr    (in_ptr),
    .in_len    (in_len),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .out_ptr   (out_ptr),
    .out_exact (out_exact),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp_v);
    end
  endtask

  // Called at a falling edge; returns there with lat = SEARCH cycles before out_vld.
  task automatic send(input logic [63:0] p, input logic [40:0] l, output int lat);
    int guard;
    in_ptr = p;
    in_len = l;
    in_vld = 1'b1;
    guard  = 0;
    while (!in_rdy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_rdy) chk("send_rdy", 64'(in_rdy), 64'd1);
    @(negedge clk);
    in_vld = 1'b0;
    lat = 0;
    while (!out_vld && lat < 64) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Consume the current result with a one-cycle handshake.
  task automatic take(input string tag);
    out_rdy = 1'b1;
    @(negedge clk);
    out_rdy = 1'b0;
    chk({tag, "_vld_drop"}, 64'(out_vld), 64'd0);
  endtask

  task automatic check_res(input string tag, input logic [63:0] exp_ptr,
                           input logic exp_exact, input logic exp_err);
    chk({tag, "_vld"},   64'(out_vld),   64'd1);
    chk({tag, "_ptr"},   out_ptr,        exp_ptr);
    chk({tag, "_exact"}, 64'(out_exact), 64'(exp_exact));
    chk({tag, "_err"},   64'(out_err),   64'(exp_err));
  endtask

  initial begin
    int lat;
    int seen;
    logic [63:0] held_ptr;

    rst     = 1'b1;
    in_vld  = 1'b0;
    in_ptr  = '0;
    in_len  = '0;
    out_rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_rdy", 64'(in_rdy), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_vld",   64'(out_vld),   64'd0);
    chk("reset_ptr",   out_ptr,        64'd0);
    chk("reset_exact", 64'(out_exact), 64'd0);
    chk("reset_err",   64'(out_err),   64'd0);
    chk("reset_rdy",   64'(in_rdy),    64'd1);

    // Small exact range: B=0x100, len 16 -> exp0 low 0 hi 7.
    send(64'hFFFF_F000_0000_1005, 41'd16, lat);
    check_res("small", 64'h0070_1000_0000_1005, 1'b1, 1'b0);
    chk("small_lat", 64'(lat), 64'd1);
    take("small");

    // Round-up: B=3, len 0x100 -> exp1 low 0 hi 0x40, inexact.
    send(64'h0000_0000_0000_0030, 41'h100, lat);
    check_res("round", 64'h0C00_1000_0000_0030, 1'b0, 1'b0);
    chk("round_lat", 64'(lat), 64'd2);
    take("round");

    // Zero length is an error, pointer passes through.
    send(64'h1234_5678_9ABC_DEF0, 41'd0, lat);
    check_res("zero", 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b1);
    chk("zero_lat", 64'(lat), 64'd0);
    take("zero");

    // Top bound overflows the 40-bit granule space.
    send(64'h0000_0FFF_FFFF_FF00, 41'h20, lat);
    check_res("ovf", 64'h0000_0FFF_FFFF_FF00, 1'b0, 1'b1);
    chk("ovf_lat", 64'(lat), 64'd0);
    take("ovf");

    // Ends exactly at the last granule: legal.
    send(64'h0000_0FFF_FFFF_FF00, 41'h10, lat);
    check_res("top", 64'h07FF_1FFF_FFFF_FF00, 1'b1, 1'b0);
    take("top");

    // Wrapping window (hi < low) is legal.
    send(64'h0000_0000_0000_0FE0, 41'd4, lat);
    check_res("wrap", 64'h000F_F000_0000_0FE0, 1'b1, 1'b0);
    take("wrap");

    // Full address space -> max exponent.
    send(64'h0000_0000_0000_0000, 41'h100_0000_0000, lat);
    check_res("full", 64'hFFF0_1000_0000_0000, 1'b1, 1'b0);
`ifdef AGUSEC_ENC_FASTSTART_EN
    chk("full_lat_le2", 64'(lat <= 2), 64'd1);
`else
    chk("full_lat", 64'(lat), 64'd32);
`endif

    // Backpressure: result held, new request waits until after the handshake.
    held_ptr = out_ptr;
    in_ptr = 64'hFFFF_F000_0000_1005;
    in_len = 41'd16;
    in_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_vld", 64'(out_vld), 64'd1);
      chk("bp_ptr", out_ptr, held_ptr);
      chk("bp_exact", 64'(out_exact), 64'd1);
      chk("bp_in_rdy", 64'(in_rdy), 64'd0);
    end
    out_rdy = 1'b1;
    @(negedge clk);
    out_rdy = 1'b0;
    chk("bp_vld_drop", 64'(out_vld), 64'd0);
    chk("bp_back_idle", 64'(in_rdy), 64'd1);
    @(negedge clk);
    in_vld = 1'b0;
    chk("bp_accepted", 64'(in_rdy), 64'd0);
    seen = 0;
    while (!out_vld && seen < 64) begin
      @(negedge clk);
      seen++;
    end
    check_res("bp_next", 64'h0070_1000_0000_1005, 1'b1, 1'b0);
    take("bp_next");

    // Mid-search reset: request abandoned, nothing emitted.
    in_ptr = 64'h0;
    in_len = 41'h100_0000_0000;
    in_vld = 1'b1;
    @(negedge clk);
    in_vld = 1'b0;
    chk("mr_busy", 64'(in_rdy), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_vld", 64'(out_vld), 64'd0);
    chk("mr_rdy_in_rst", 64'(in_rdy), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("mr_rdy_after", 64'(in_rdy), 64'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_vld) seen++;
      @(negedge clk);
    end
    chk("mr_no_result", 64'(seen), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
